// File: rtl/k12_check_pkg.sv
// Shared types and constants for the K12 ALU response checker.
package k12_check_pkg;

    localparam int unsigned ERR_W = 41;
    localparam int unsigned SIG_W = 16;

    // Feedback taps of the signature register: bits 15, 13, 12, 10.
    localparam logic [SIG_W-1:0] MISR_TAPS = 16'hB400;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_FINISHED = 1'b1
    } state_t;

    // Mismatch record as queued for the logger.
    typedef struct packed {
        logic [15:0] inst;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  res;
        logic        cond;
    } err_rec_t;

    // One MISR step: shift in the tap parity, then fold in {res, cond}.
    function automatic logic [SIG_W-1:0] misr_step(
        input logic [SIG_W-1:0] sig,
        input logic [7:0]       res,
        input logic             cond
    );
        return {sig[SIG_W-2:0], ^(sig & MISR_TAPS)} ^ {7'b0, res, cond};
    endfunction

endpackage

// File: rtl/k12_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is taken
// when a pop happens in the same cycle.
module k12_sync_fifo #(
    parameter int unsigned WIDTH = 41,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign dout  = mem_q[rd_ptr_q];

    // Accept/advance decisions and next pointer/occupancy values.
    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/k12_alu_resp_checker.sv
// Result-side checker for the K12 ALU: counts, signs and logs mismatches.
module k12_alu_resp_checker
    import k12_check_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_a,
    input  logic [7:0]        in_b,
    input  logic [15:0]       in_inst,
    input  logic [7:0]        in_res,
    input  logic              in_cond,
    input  logic [7:0]        exp_res,
    input  logic              exp_cond,
    input  logic              done,
    output logic              err_valid,
    input  logic              err_ready,
    output logic [ERR_W-1:0]  err_data,
    output logic [CNT_W-1:0]  sample_count,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic [SIG_W-1:0]  signature,
    output logic              overflow,
    output logic              finished,
    output logic              pass
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   sample_count_q, sample_count_d;
    logic [CNT_W-1:0]   mismatch_count_q, mismatch_count_d;
    logic [SIG_W-1:0]   signature_q, signature_d;
    logic               overflow_q, overflow_d;
    logic               finished_q, finished_d;
    logic               pass_q, pass_d;

    logic               accept;
    logic               mismatch;
    logic               pop_c;
    logic               fifo_empty;
    logic               fifo_full;
    logic [ERR_W-1:0]   fifo_dout;
    err_rec_t           rec;

    // Mismatch record queue towards the logger.
    k12_sync_fifo #(
        .WIDTH (ERR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (mismatch),
        .din   (rec),
        .pop   (err_ready),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Sample classification, FSM next state, counters, MISR and status.
    always_comb begin
        rec      = '{inst: in_inst, a: in_a, b: in_b, res: in_res, cond: in_cond};
        accept   = in_valid && (state_q == ST_RUN);
        mismatch = accept && ((in_res != exp_res) || (in_cond != exp_cond));
        pop_c    = !fifo_empty && err_ready;

        state_d          = state_q;
        sample_count_d   = sample_count_q;
        mismatch_count_d = mismatch_count_q;
        signature_d      = signature_q;
        overflow_d       = overflow_q;

        if (state_q == ST_RUN && done) state_d = ST_FINISHED;

        if (accept) begin
            signature_d = misr_step(signature_q, in_res, in_cond);
            if (sample_count_q != '1) sample_count_d = sample_count_q + CNT_W'(1);
        end
        if (mismatch && mismatch_count_q != '1) begin
            mismatch_count_d = mismatch_count_q + CNT_W'(1);
        end
        if (mismatch && fifo_full && !pop_c) overflow_d = 1'b1;

        finished_d = (state_d == ST_FINISHED);
        pass_d     = finished_d && (mismatch_count_d == '0) && !overflow_d;
    end

    // State, counter and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_RUN;
            sample_count_q   <= '0;
            mismatch_count_q <= '0;
            signature_q      <= '0;
            overflow_q       <= 1'b0;
            finished_q       <= 1'b0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            sample_count_q   <= sample_count_d;
            mismatch_count_q <= mismatch_count_d;
            signature_q      <= signature_d;
            overflow_q       <= overflow_d;
            finished_q       <= finished_d;
            pass_q           <= pass_d;
        end
    end

    assign err_valid      = !fifo_empty;
    assign err_data       = fifo_dout;
    assign sample_count   = sample_count_q;
    assign mismatch_count = mismatch_count_q;
    assign signature      = signature_q;
    assign overflow       = overflow_q;
    assign finished       = finished_q;
    assign pass           = pass_q;

endmodule

// File: tb/tb_k12_alu_resp_checker.sv
// Directed, table-driven bench for k12_alu_resp_checker.
module tb_k12_alu_resp_checker;

    localparam int unsigned CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_a, in_b, in_res, exp_res;
    logic [15:0] in_inst;
    logic        in_cond, exp_cond, done, err_ready;
    logic        err_valid, overflow, finished, pass;
    logic [40:0] err_data;
    logic [CNT_W-1:0] sample_count, mismatch_count;
    logic [15:0] signature;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    k12_alu_resp_checker #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_inst        (in_inst),
        .in_res         (in_res),
        .in_cond        (in_cond),
        .exp_res        (exp_res),
        .exp_cond       (exp_cond),
        .done           (done),
        .err_valid      (err_valid),
        .err_ready      (err_ready),
        .err_data       (err_data),
        .sample_count   (sample_count),
        .mismatch_count (mismatch_count),
        .signature      (signature),
        .overflow       (overflow),
        .finished       (finished),
        .pass           (pass)
    );

    typedef struct {
        logic        rst, v;
        logic [7:0]  a, b;
        logic [15:0] inst;
        logic [7:0]  res;
        logic        cnd;
        logic [7:0]  eres;
        logic        econd, dn, rdy;
        logic [3:0]  scnt, mcnt;
        logic        ev, edc;
        logic [40:0] ed;
        logic        ovf, fin, pas, sigc;
        logic [15:0] sig;
    } vec_t;

    vec_t tbl[$];

    task automatic row(
        input logic rst_i, v, input logic [7:0] a, b, input logic [15:0] inst,
        input logic [7:0] res, input logic cnd, input logic [7:0] eres,
        input logic econd, dn, rdy, input logic [3:0] scnt, mcnt,
        input logic ev, edc, input logic [40:0] ed,
        input logic ovf, fin, pas, sigc, input logic [15:0] sig
    );
        vec_t r;
        r.rst = rst_i; r.v = v; r.a = a; r.b = b; r.inst = inst; r.res = res;
        r.cnd = cnd; r.eres = eres; r.econd = econd; r.dn = dn; r.rdy = rdy;
        r.scnt = scnt; r.mcnt = mcnt; r.ev = ev; r.edc = edc; r.ed = ed;
        r.ovf = ovf; r.fin = fin; r.pas = pas; r.sigc = sigc; r.sig = sig;
        tbl.push_back(r);
    endtask

    // Reset cycle: every output at its reset value.
    task automatic row_rst();
        row(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,'0, 0,0,0,1,16'h0000);
    endtask

    // Canonical mismatch record k: a=k, b=0x10+k, inst=0x1000+k, res=k, cond=0.
    function automatic logic [40:0] ent(input int k);
        return {16'h1000 + 16'(k), 8'(k), 8'h10 + 8'(k), 8'(k), 1'b0};
    endfunction

    task automatic row_mis(input int k, input logic rdy, input logic [3:0] cnt,
                           input int head, input logic ovf);
        row(0,1,8'(k),8'h10+8'(k),16'h1000+16'(k),8'(k),0,8'h00,0,0,rdy,
            cnt,cnt,1,1,ent(head), ovf,0,0,0,16'h0);
    endtask

    task automatic row_drain(input logic [3:0] cnt, input logic ev, input int head,
                             input logic ovf);
        row(0,0,0,0,0,0,0,0,0,0,1, cnt,cnt,ev,ev,ent(head), ovf,0,0,0,16'h0);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        rst = r.rst; in_valid = r.v; in_a = r.a; in_b = r.b; in_inst = r.inst;
        in_res = r.res; in_cond = r.cnd; exp_res = r.eres; exp_cond = r.econd;
        done = r.dn; err_ready = r.rdy;
    endtask

    task automatic check_row(input int i, input vec_t r);
        chk($sformatf("row%0d sample_count", i), 64'(sample_count), 64'(r.scnt));
        chk($sformatf("row%0d mismatch_count", i), 64'(mismatch_count), 64'(r.mcnt));
        chk($sformatf("row%0d err_valid", i), 64'(err_valid), 64'(r.ev));
        chk($sformatf("row%0d overflow", i), 64'(overflow), 64'(r.ovf));
        chk($sformatf("row%0d finished", i), 64'(finished), 64'(r.fin));
        chk($sformatf("row%0d pass", i), 64'(pass), 64'(r.pas));
        if (r.edc) chk($sformatf("row%0d err_data", i), 64'(err_data), 64'(r.ed));
        if (r.sigc) chk($sformatf("row%0d signature", i), 64'(signature), 64'(r.sig));
    endtask

    initial begin
        vec_t idle;
        idle = '{default: '0};
        drive(idle);

        // Matching samples, then done -> pass.
        row_rst();
        for (int k = 1; k <= 3; k++)
            row(0,1,0,0,0,0,0,0,0,0,0, 4'(k),0,0,0,'0, 0,0,0,1,16'h0000);
        row(0,0,0,0,0,0,0,0,0,1,0, 3,0,0,0,'0, 0,1,1,1,16'h0000);
        row(0,0,0,0,0,0,0,0,0,0,0, 3,0,0,0,'0, 0,1,1,1,16'h0000);
        // Signature steps.
        row_rst();
        row(0,1,0,0,0,8'hFF,1,8'hFF,1,0,0, 1,0,0,0,'0, 0,0,0,1,16'h01FF);
        row(0,1,0,0,0,8'h00,0,8'h00,0,0,0, 2,0,0,0,'0, 0,0,0,1,16'h03FE);
        // Single mismatch recorded, then popped.
        row_rst();
        row(0,1,8'h7F,8'h01,16'h0080,8'h7E,0,8'h80,0,0,0,
            1,1,1,1,{16'h0080,8'h7F,8'h01,8'h7E,1'b0}, 0,0,0,1,16'h00FC);
        row(0,0,0,0,0,0,0,0,0,0,0,
            1,1,1,1,{16'h0080,8'h7F,8'h01,8'h7E,1'b0}, 0,0,0,1,16'h00FC);
        row(0,0,0,0,0,0,0,0,0,0,1, 1,1,0,0,'0, 0,0,0,1,16'h00FC);
        // Five mismatches into a depth-4 FIFO with no drain -> overflow.
        row_rst();
        for (int k = 1; k <= 5; k++) row_mis(k, 0, 4'(k), 1, k == 5);
        for (int h = 2; h <= 4; h++) row_drain(5, 1, h, 1);
        row_drain(5, 0, 0, 1);
        // Full FIFO with simultaneous pop accepts the push.
        row_rst();
        for (int k = 1; k <= 4; k++) row_mis(k, 0, 4'(k), 1, 0);
        row_mis(5, 1, 5, 2, 0);
        for (int h = 3; h <= 5; h++) row_drain(5, 1, h, 0);
        row_drain(5, 0, 0, 0);
        // done with a same-cycle sample, then ignored samples, then reset.
        row_rst();
        row(0,1,0,0,0,0,0,0,0,0,0, 1,0,0,0,'0, 0,0,0,1,16'h0000);
        row(0,1,8'h55,8'h66,16'hABCD,8'h01,0,8'h00,0,1,0,
            2,1,1,1,{16'hABCD,8'h55,8'h66,8'h01,1'b0}, 0,1,0,1,16'h0002);
        for (int k = 0; k < 2; k++)
            row(0,1,8'h11,8'h22,16'h3333,8'hAA,1,8'h00,0,0,0,
                2,1,1,1,{16'hABCD,8'h55,8'h66,8'h01,1'b0}, 0,1,0,1,16'h0002);
        row(0,0,0,0,0,0,0,0,0,0,1, 2,1,0,0,'0, 0,1,0,1,16'h0002);
        row_rst();
        row(0,0,0,0,0,0,0,0,0,1,0, 0,0,0,0,'0, 0,1,1,1,16'h0000);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check_row(i, tbl[i]);
        end

        // Counter saturation at all-ones with the 4-bit counter build.
        @(negedge clk);
        drive(idle);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1; in_res = 8'h01; exp_res = 8'h00; err_ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 14) chk("sat pre sample_count", 64'(sample_count), 64'd14);
            if (k == 15) chk("sat at sample_count", 64'(sample_count), 64'd15);
            @(negedge clk);
        end
        chk("sat sample_count", 64'(sample_count), 64'd15);
        chk("sat mismatch_count", 64'(mismatch_count), 64'd15);
        chk("sat overflow", 64'(overflow), 64'd0);
        in_valid = 1'b0;
        done = 1'b1;
        @(posedge clk);
        #1;
        chk("sat finished", 64'(finished), 64'd1);
        chk("sat pass", 64'(pass), 64'd0);
        @(negedge clk);
        done = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post rst sample_count", 64'(sample_count), 64'd0);
        chk("post rst finished", 64'(finished), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/k12_alu_resp_checker.md
# k12_alu_resp_checker

Sequential response checker sitting on the result side of the K12 ALU (`k12_alu_ttl`) in bring-up and self-test builds. A stimulus source presents each ALU transaction (`a`, `b`, `inst`), the ALU's outputs (`res`, `cond`) and the golden model's expected outputs. The checker performs four jobs:
- counts samples and mismatches;
- folds the ALU outputs into a 16-bit MISR signature;
- queues the first mismatching transactions in a small FIFO;
- drains the FIFO to a logger over a ready/valid handshake.

## Interface
Parameters:
- `FIFO_DEPTH`, 4 — mismatch FIFO entries; power of two, ≥2.
- `CNT_W`, 16 — width of the sample and mismatch counters.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  — sole clock; all state changes on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — sample present this cycle. No backpressure; every valid sample is consumed.
- `in_a`  in  8  — ALU operand A.
- `in_b`  in  8  — ALU operand B.
- `in_inst`  in  16  — instruction word.
- `in_res`  in  8  — ALU result under test.
- `in_cond`  in  1  — ALU condition output under test.
- `exp_res`  in  8  — golden result.
- `exp_cond`  in  1  — golden condition.
- `done`  in  1  — end-of-run strobe.
- `err_valid`  out  1  — FIFO head valid.
- `err_ready`  in  1  — logger accepts the FIFO head.
- `err_data`  out  41  — FIFO head, packed `{inst[15:0], a[7:0], b[7:0], res[7:0], cond}`.
- `sample_count`  out  CNT_W  — samples accepted.
- `mismatch_count`  out  CNT_W  — mismatching samples.
- `signature`  out  16  — MISR value.
- `overflow`  out  1  — sticky; set when a mismatch is dropped because the FIFO is full.
- `finished`  out  1  — high in the FINISHED state.
- `pass`  out  1  — `finished && mismatch_count==0 && !overflow`.

## Operation
- States: RUN (entered on reset) and FINISHED.
  - RUN → FINISHED when `done` is high.
  - FINISHED → RUN only through `rst`.
  - If `done` and `in_valid` are high in the same cycle, the sample is still consumed before the state changes.
- An accepted sample is `in_valid && state==RUN`. In FINISHED, `in_valid` is ignored. FIFO draining continues in both states.
- Mismatch = `(in_res != exp_res) || (in_cond != exp_cond)`. Operands and instruction are not checked; they are only recorded.
- Counters:
  - `sample_count` increments on each accepted sample.
  - `mismatch_count` increments on each accepted mismatch.
  - Both saturate at all-ones and never wrap.
- MISR, per accepted sample: `sig_next = {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ {7'b0, in_res, in_cond}`.
- FIFO push happens on an accepted mismatch.
  - Push succeeds if the FIFO is not full, or if it is full and a pop (`err_valid && err_ready`) occurs in the same cycle.
  - Otherwise the entry is dropped and `overflow` is set. `overflow` stays set until reset.
- FIFO pop on `err_valid && err_ready`. The FIFO is first-word-fall-through: `err_data` shows the head while `err_valid` is high. `err_data` is don't-care when `err_valid` is low. Entries leave in arrival order.
- Reset values:
  - `err_valid`, `sample_count`, `mismatch_count`, `overflow`, `finished`, `pass` = 0.
  - `signature` = 16'h0000.
  - FIFO emptied.
  - Reset mid-run discards all queued entries and counts.

## Timing
- All outputs are registered.
- Counters and `signature` reflect a sample on the cycle after it is presented.
- A mismatch pushed at edge N has `err_valid` high from edge N+1 when the FIFO was empty.
- `finished` and `pass` go high one cycle after `done`.
- Throughput: one sample per clock, sustained indefinitely.

## Structure
- Shared package `k12_check_pkg`:
  - `ERR_W` = 41;
  - MISR tap constant;
  - state enum {RUN, FINISHED};
  - err-record pack/unpack typedef.
- Sub-module `k12_sync_fifo` (parameterised width/depth, FWFT, with full/empty flags and simultaneous push/pop when full).
- Counters, MISR and FSM stay in the top level.

## Test plan
- Reset, then 3 samples with `in_res==exp_res`, `in_cond==exp_cond` → `sample_count`=3, `mismatch_count`=0, `err_valid`=0. After `done`: `finished`=1, `pass`=1.
- From reset, one sample `in_res`=8'hFF, `in_cond`=1 → `signature`=16'h01FF. A second sample with `res`=8'h00, `cond`=0 → `signature`=16'h03FE.
- Mismatch: `a`=8'h7F, `b`=8'h01, `inst`=16'h0080, `res`=8'h7E, `exp_res`=8'h80, `err_ready`=0 → next cycle `err_valid`=1, `err_data`={16'h0080, 8'h7F, 8'h01, 8'h7E, cond}, `mismatch_count`=1.
- `err_ready`=0, 5 consecutive mismatches with `FIFO_DEPTH`=4 → 4 entries held in order, `overflow`=1, `mismatch_count`=5. Then `err_ready`=1 drains 4 entries; `err_valid` falls after the 4th pop.
- FIFO full, mismatch presented with `err_ready`=1 in the same cycle → entry accepted, `overflow` stays 0.
- `done` asserted, then 2 further mismatches → counts unchanged, `finished`=1. `rst` pulse → all outputs return to reset values.
